// File: rtl/alu_secuencial.sv
// Multi-cycle ALU: single-cycle add/sub/pass, one-bit-per-cycle shifts and an optional
// N-cycle shift-add multiplier enabled by defining ALU_MUL_EN.
module alu_secuencial #(
    parameter int unsigned N = 16,
    localparam int unsigned SW = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [2:0]   i_control,
    output logic         o_busy,
    output logic         o_done,
    output logic [N-1:0] q,
    output logic [N-1:0] q_hi,
    output logic         mayor,
    output logic         zero,
    output logic         paridad
);

    // Counter must hold N for the multiplier, hence one bit wider than SW.
    localparam int unsigned CW = SW + 1;

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StRun  = 1'b1;

    localparam logic [2:0] OpSuma  = 3'b000;
    localparam logic [2:0] OpShr   = 3'b001;
    localparam logic [2:0] OpResta = 3'b010;
    localparam logic [2:0] OpShl   = 3'b011;
    localparam logic [2:0] OpPassB = 3'b100;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OpMul   = 3'b110;
`endif

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sh_q, sh_d;
    logic          left_q, left_d;
    logic [N-1:0]  q_q, q_d;
    logic          mayor_q, mayor_d;
    logic          zero_q, zero_d;
    logic          par_q, par_d;
    logic          done_q, done_d;

    logic [SW-1:0] k_w;
    logic [N:0]    sum_w;
    logic [N:0]    diff_w;
    logic [N-1:0]  sh_next_w;
    logic          out_bit_w;
    logic [N-1:0]  run_lo_w;
    logic          run_mayor_w;

    assign k_w    = i_b[SW-1:0];
    assign sum_w  = {1'b0, i_a} + {1'b0, i_b};
    assign diff_w = {1'b0, i_a} - {1'b0, i_b};

    assign sh_next_w = left_q ? {sh_q[N-2:0], 1'b0} : {1'b0, sh_q[N-1:1]};
    assign out_bit_w = left_q ? sh_q[N-1] : sh_q[0];

`ifdef ALU_MUL_EN
    logic [N-1:0] acc_q, acc_d;
    logic [N-1:0] mcand_q, mcand_d;
    logic [N-1:0] q_hi_q, q_hi_d;
    logic         mul_q, mul_d;
    logic [N:0]   acc_sum_w;
    logic [N-1:0] run_hi_w;

    // {acc, multiplier} shifts right as a 2N-bit pair; the product ends up in it.
    assign acc_sum_w   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, mcand_q} : '0);
    assign run_lo_w    = mul_q ? {acc_sum_w[0], sh_q[N-1:1]} : sh_next_w;
    assign run_hi_w    = mul_q ? acc_sum_w[N:1] : '0;
    assign run_mayor_w = mul_q ? (|acc_sum_w[N:1]) : out_bit_w;
`else
    assign run_lo_w    = sh_next_w;
    assign run_mayor_w = out_bit_w;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        left_d  = left_q;
        q_d     = q_q;
        mayor_d = mayor_q;
        zero_d  = zero_q;
        par_d   = par_q;
        done_d  = 1'b0;
`ifdef ALU_MUL_EN
        acc_d   = acc_q;
        mcand_d = mcand_q;
        q_hi_d  = q_hi_q;
        mul_d   = mul_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    case (i_control)
                        OpSuma: begin
                            q_d     = sum_w[N-1:0];
                            mayor_d = sum_w[N];
                            done_d  = 1'b1;
                        end
                        OpResta: begin
                            q_d     = diff_w[N-1:0];
                            mayor_d = diff_w[N];
                            done_d  = 1'b1;
                        end
                        OpShr, OpShl: begin
                            if (k_w == '0) begin
                                q_d     = i_a;
                                mayor_d = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                sh_d    = i_a;
                                left_d  = i_control[1];
                                cnt_d   = CW'(k_w);
                                state_d = StRun;
`ifdef ALU_MUL_EN
                                mul_d   = 1'b0;
`endif
                            end
                        end
                        OpPassB: begin
                            q_d     = i_b;
                            mayor_d = 1'b0;
                            done_d  = 1'b1;
                        end
`ifdef ALU_MUL_EN
                        OpMul: begin
                            sh_d    = i_b;
                            mcand_d = i_a;
                            acc_d   = '0;
                            cnt_d   = CW'(N);
                            mul_d   = 1'b1;
                            state_d = StRun;
                        end
`endif
                        default: begin
                            q_d     = i_a;
                            mayor_d = 1'b0;
                            done_d  = 1'b1;
                        end
                    endcase
`ifdef ALU_MUL_EN
                    if (done_d) begin
                        q_hi_d = '0;
                    end
`endif
                end
            end
            StRun: begin
                cnt_d = cnt_q - CW'(1);
                sh_d  = run_lo_w;
`ifdef ALU_MUL_EN
                acc_d = run_hi_w;
`endif
                if (cnt_q == CW'(1)) begin
                    state_d = StIdle;
                    q_d     = run_lo_w;
                    mayor_d = run_mayor_w;
                    done_d  = 1'b1;
`ifdef ALU_MUL_EN
                    q_hi_d  = run_hi_w;
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (done_d) begin
`ifdef ALU_MUL_EN
            zero_d = ({q_hi_d, q_d} == '0);
`else
            zero_d = (q_d == '0);
`endif
            par_d  = q_d[0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            sh_q    <= '0;
            left_q  <= 1'b0;
            q_q     <= '0;
            mayor_q <= 1'b0;
            zero_q  <= 1'b0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            left_q  <= left_d;
            q_q     <= q_d;
            mayor_q <= mayor_d;
            zero_q  <= zero_d;
            par_q   <= par_d;
            done_q  <= done_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            acc_q   <= '0;
            mcand_q <= '0;
            q_hi_q  <= '0;
            mul_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            q_hi_q  <= q_hi_d;
            mul_q   <= mul_d;
        end
    end

    assign q_hi = q_hi_q;
`else
    assign q_hi = '0;
`endif

    assign o_busy  = (state_q == StRun);
    assign o_done  = done_q;
    assign q       = q_q;
    assign mayor   = mayor_q;
    assign zero    = zero_q;
    assign paridad = par_q;

endmodule

// File: tb/tb_alu_secuencial.sv
// Directed bench for alu_secuencial (N=16); follows ALU_MUL_EN for the multiply vectors.
module tb_alu_secuencial;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic [2:0]  i_control;
    logic        o_busy;
    logic        o_done;
    logic [15:0] q;
    logic [15:0] q_hi;
    logic        mayor;
    logic        zero;
    logic        paridad;

    int unsigned checks = 0;
    int unsigned errors = 0;

    alu_secuencial #(.N(16)) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (i_start),
        .i_a       (i_a),
        .i_b       (i_b),
        .i_control (i_control),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .q         (q),
        .q_hi      (q_hi),
        .mayor     (mayor),
        .zero      (zero),
        .paridad   (paridad)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        int unsigned lat;  // busy cycles before o_done
        logic [15:0] eq;
        logic [15:0] ehi;
        logic        em;
        logic        ez;
        logic        ep;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where o_done is seen.
    task automatic run_op(input vec_t v, input string nm, input bit inject,
                          input logic [15:0] prev_q);
        int unsigned nb;
        bit seen;
        nb = 0;
        seen = 1'b0;
        i_start = 1'b1;
        i_control = v.op;
        i_a = v.a;
        i_b = v.b;
        @(negedge i_clk);
        i_start = 1'b0;
        i_control = ~v.op;
        i_a = ~v.a;
        i_b = ~v.b;
        for (int c = 0; c < 40 && !seen; c++) begin
            check({nm, "_excl"}, {31'b0, o_busy & o_done}, 32'd0);
            if (o_done) begin
                seen = 1'b1;
            end else begin
                if (o_busy) nb++;
                if (inject && nb == 5) check({nm, "_hold"}, {16'b0, q}, {16'b0, prev_q});
                if (inject && nb == 3) begin
                    i_start = 1'b1;
                    i_control = 3'b000;
                    i_a = 16'h0001;
                    i_b = 16'h0001;
                end
                @(negedge i_clk);
                i_start = 1'b0;
            end
        end
        check({nm, "_done"}, {31'b0, seen}, 32'd1);
        check({nm, "_busy"}, nb, v.lat);
        check({nm, "_q"}, {16'b0, q}, {16'b0, v.eq});
        check({nm, "_qhi"}, {16'b0, q_hi}, {16'b0, v.ehi});
        check({nm, "_mayor"}, {31'b0, mayor}, {31'b0, v.em});
        check({nm, "_zero"}, {31'b0, zero}, {31'b0, v.ez});
        check({nm, "_par"}, {31'b0, paridad}, {31'b0, v.ep});
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_q"}, {16'b0, q}, 32'd0);
        check({nm, "_qhi"}, {16'b0, q_hi}, 32'd0);
        check({nm, "_flags"}, {29'b0, mayor, zero, paridad}, 32'd0);
        check({nm, "_busy"}, {31'b0, o_busy}, 32'd0);
        check({nm, "_done"}, {31'b0, o_done}, 32'd0);
    endtask

    initial begin
        vec_t t;
        int unsigned ndone;

        //          op      a         b        lat  q         q_hi      m     z     p
        vecs[0]  = '{3'b000, 16'hFFFF, 16'h0001, 0,  16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{3'b010, 16'h0003, 16'h0005, 0,  16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b011, 16'h8001, 16'h0003, 3,  16'h0008, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b011, 16'h8001, 16'h0001, 1,  16'h0002, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 16'h00F3, 16'h0000, 0,  16'h00F3, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{3'b000, 16'h1234, 16'h4321, 0,  16'h5555, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{3'b010, 16'h0005, 16'h0003, 0,  16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{3'b010, 16'h0007, 16'h0007, 0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{3'b100, 16'h1111, 16'hABCD, 0,  16'hABCD, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b101, 16'h1357, 16'hFFFF, 0,  16'h1357, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{3'b111, 16'h0000, 16'h1234, 0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{3'b001, 16'h8000, 16'h000F, 15, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b001, 16'h00F3, 16'hFFF2, 2,  16'h003C, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{3'b011, 16'h0001, 16'h000F, 15, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{3'b011, 16'hFFFF, 16'h0010, 0,  16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1};
`ifdef ALU_MUL_EN
        vecs[15] = '{3'b110, 16'hFFFF, 16'hFFFF, 16, 16'h0001, 16'hFFFE, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{3'b110, 16'h0100, 16'h0100, 16, 16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{3'b110, 16'h0000, 16'h1234, 16, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
`else
        vecs[15] = '{3'b110, 16'hFFFF, 16'hFFFF, 0,  16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{3'b110, 16'h0100, 16'h0100, 0,  16'h0100, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{3'b110, 16'h0000, 16'h1234, 0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
`endif

        i_reset = 1'b1;
        i_start = 1'b0;
        i_a = '0;
        i_b = '0;
        i_control = '0;
        repeat (2) @(negedge i_clk);
        check_all_zero("reset");
        i_reset = 1'b0;
        @(negedge i_clk);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i), 1'b0, 16'h0000);
            @(negedge i_clk);
        end

        // Back-to-back: second start issued in the o_done cycle of the first.
        t = '{3'b000, 16'h0001, 16'h0001, 0, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0};
        run_op(t, "b2b_a", 1'b0, 16'h0000);
        t = '{3'b010, 16'h0002, 16'h0003, 0, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1};
        run_op(t, "b2b_b", 1'b0, 16'h0000);
        @(negedge i_clk);

        // Start pulsed mid-shift must be ignored; result held during RUN.
        t = '{3'b001, 16'h8000, 16'h000F, 15, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1};
        run_op(t, "ign", 1'b1, 16'hFFFF);
        @(negedge i_clk);

        // Reset in the middle of a long operation aborts it.
`ifdef ALU_MUL_EN
        i_control = 3'b110;
        i_b = 16'h0010;
`else
        i_control = 3'b001;
        i_b = 16'h000F;
`endif
        i_a = 16'h1234;
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("abort_busy_pre", {31'b0, o_busy}, 32'd1);
        repeat (4) @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge i_clk);
        i_reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge i_clk);
            if (o_done) ndone++;
        end
        check("abort_nodone", ndone, 32'd0);
        check_all_zero("abort_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
